// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
//
// Instruction queue sitting between the fetcher and the dispatch stage. The
// fetcher pushes raw instructions with their PC and branch-prediction bit; the
// queue decodes the head entry (target unit, operand usage, rd write, immediate)
// and issues at most one instruction per cycle to either the reservation
// station (RS) or the load/store buffer (LSB) once downstream has room.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   rdy_in                global enable; low freezes queue state
//   in_fetch_*            fetcher offer: valid, instruction, PC, predict bit
//   out_fetch_full        queue holds DEPTH entries, fetcher must stall
//   in_flush              rollback: discard all queued and in-flight work
//   in_rob/rs/lsb_full    downstream capacity flags
//   out_issue_valid       one-cycle pulse marking the registered issue fields
//   out_to_lsb            1 = LSB target, 0 = RS target
//   out_inst/pc/imm       raw instruction, PC, decoded immediate
//   out_rd/rs1/rs2        register fields
//   out_use_rs1/rs2       operand usage flags
//   out_reg_write         instruction writes a non-zero rd
//   out_predict           predictor bit carried with the instruction
// -----------------------------------------------------------------------------
module decode_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,

    input  logic            in_fetch_valid,
    input  logic [XLEN-1:0] in_fetch_inst,
    input  logic [XLEN-1:0] in_fetch_pc,
    input  logic            in_fetch_predict,
    output logic            out_fetch_full,

    input  logic            in_flush,
    input  logic            in_rob_full,
    input  logic            in_rs_full,
    input  logic            in_lsb_full,

    output logic            out_issue_valid,
    output logic            out_to_lsb,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_use_rs1,
    output logic            out_use_rs2,
    output logic            out_reg_write,
    output logic            out_predict
);

    // RV32I major opcodes
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);

    // -------------------------------------------------------------------------
    // Storage and pointers
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] mem_inst_q [DEPTH];
    logic [XLEN-1:0] mem_pc_q   [DEPTH];
    logic            mem_pred_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    // Registered issue outputs
    logic            issue_valid_q, issue_valid_d;
    logic            to_lsb_q, to_lsb_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic            use_rs1_q, use_rs1_d;
    logic            use_rs2_q, use_rs2_d;
    logic            reg_write_q, reg_write_d;
    logic            predict_q, predict_d;

    // -------------------------------------------------------------------------
    // Head-entry decode
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] head_inst;
    logic [6:0]      dec_opcode;
    logic [2:0]      dec_funct3;
    logic            dec_known;
    logic            dec_to_lsb;
    logic            dec_use_rs1;
    logic            dec_use_rs2;
    logic            dec_reg_write;
    logic [XLEN-1:0] dec_imm;

    assign head_inst  = mem_inst_q[head_q];
    assign dec_opcode = head_inst[6:0];
    assign dec_funct3 = head_inst[14:12];

    always_comb begin
        dec_known   = 1'b1;
        dec_to_lsb  = 1'b0;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b0;
        dec_imm     = '0;
        unique case (dec_opcode)
            OpLui, OpAuipc: begin
                dec_use_rs1 = 1'b0;
                dec_imm     = XLEN'($signed({head_inst[31:12], 12'b0}));
            end
            OpJal: begin
                dec_use_rs1 = 1'b0;
                dec_imm     = XLEN'($signed({head_inst[31], head_inst[19:12], head_inst[20],
                                             head_inst[30:21], 1'b0}));
            end
            OpJalr: begin
                dec_imm = XLEN'($signed(head_inst[31:20]));
            end
            OpLoad: begin
                dec_to_lsb = 1'b1;
                dec_imm    = XLEN'($signed(head_inst[31:20]));
            end
            OpStore: begin
                dec_to_lsb  = 1'b1;
                dec_use_rs2 = 1'b1;
                dec_imm     = XLEN'($signed({head_inst[31:25], head_inst[11:7]}));
            end
            OpBranch: begin
                dec_use_rs2 = 1'b1;
                dec_imm     = XLEN'($signed({head_inst[31], head_inst[7], head_inst[30:25],
                                             head_inst[11:8], 1'b0}));
            end
            OpImm: begin
                // Shift-immediates carry an unsigned shamt, not a signed constant
                if (dec_funct3 == 3'b001 || dec_funct3 == 3'b101) begin
                    dec_imm = XLEN'(head_inst[24:20]);
                end else begin
                    dec_imm = XLEN'($signed(head_inst[31:20]));
                end
            end
            OpReg: begin
                dec_use_rs2 = 1'b1;
            end
            default: begin
                // Unknown opcodes still drain through the RS as inert entries
                dec_known   = 1'b0;
                dec_use_rs1 = 1'b0;
            end
        endcase
    end

    assign dec_reg_write = dec_known && (dec_opcode != OpStore) && (dec_opcode != OpBranch) &&
                           (head_inst[11:7] != 5'd0);

    // -------------------------------------------------------------------------
    // Enqueue / dequeue control
    // -------------------------------------------------------------------------
    logic enq;
    logic deq;
    logic blocked;

    assign enq     = in_fetch_valid && rdy_in && !in_flush && (count_q < FullCnt);
    assign blocked = in_rob_full || (dec_to_lsb ? in_lsb_full : in_rs_full);
    assign deq     = (count_q != '0) && rdy_in && !in_flush && !blocked;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        // Pulse: cleared on every edge without an issue, including rdy_in low
        issue_valid_d = 1'b0;
        to_lsb_d      = to_lsb_q;
        inst_d        = inst_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        use_rs1_d     = use_rs1_q;
        use_rs2_d     = use_rs2_q;
        reg_write_d   = reg_write_q;
        predict_d     = predict_q;

        if (in_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end

        if (deq) begin
            issue_valid_d = 1'b1;
            to_lsb_d      = dec_to_lsb;
            inst_d        = head_inst;
            pc_d          = mem_pc_q[head_q];
            imm_d         = dec_imm;
            rd_d          = head_inst[11:7];
            rs1_d         = head_inst[19:15];
            rs2_d         = head_inst[24:20];
            use_rs1_d     = dec_use_rs1;
            use_rs2_d     = dec_use_rs2;
            reg_write_d   = dec_reg_write;
            predict_d     = mem_pred_q[head_q];
        end
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // Entry payload needs no reset: count gates every read of it.
    always_ff @(posedge clk_in) begin
        if (enq) begin
            mem_inst_q[tail_q] <= in_fetch_inst;
            mem_pc_q[tail_q]   <= in_fetch_pc;
            mem_pred_q[tail_q] <= in_fetch_predict;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            to_lsb_q      <= 1'b0;
            inst_q        <= '0;
            pc_q          <= '0;
            imm_q         <= '0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            use_rs1_q     <= 1'b0;
            use_rs2_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            predict_q     <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            to_lsb_q      <= to_lsb_d;
            inst_q        <= inst_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            use_rs1_q     <= use_rs1_d;
            use_rs2_q     <= use_rs2_d;
            reg_write_q   <= reg_write_d;
            predict_q     <= predict_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_fetch_full  = (count_q == FullCnt);
    assign out_issue_valid = issue_valid_q;
    assign out_to_lsb      = to_lsb_q;
    assign out_inst        = inst_q;
    assign out_pc          = pc_q;
    assign out_imm         = imm_q;
    assign out_rd          = rd_q;
    assign out_rs1         = rs1_q;
    assign out_rs2         = rs2_q;
    assign out_use_rs1     = use_rs1_q;
    assign out_use_rs2     = use_rs2_q;
    assign out_reg_write   = reg_write_q;
    assign out_predict     = predict_q;

endmodule

// File: tb/tb_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_queue
//
// Directed scenarios followed by a randomized run. Expected behaviour comes
// from a transaction-level model: a queue of fetched entries plus a decode
// function that derives fields and immediates arithmetically from RV32I rules.
// -----------------------------------------------------------------------------
module tb_decode_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int XLEN  = 32;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            rdy_in;
    logic            in_fetch_valid;
    logic [XLEN-1:0] in_fetch_inst;
    logic [XLEN-1:0] in_fetch_pc;
    logic            in_fetch_predict;
    logic            out_fetch_full;
    logic            in_flush;
    logic            in_rob_full;
    logic            in_rs_full;
    logic            in_lsb_full;
    logic            out_issue_valid;
    logic            out_to_lsb;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic            out_use_rs1;
    logic            out_use_rs2;
    logic            out_reg_write;
    logic            out_predict;

    decode_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .XLEN  (XLEN)
    ) u_dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .in_fetch_valid   (in_fetch_valid),
        .in_fetch_inst    (in_fetch_inst),
        .in_fetch_pc      (in_fetch_pc),
        .in_fetch_predict (in_fetch_predict),
        .out_fetch_full   (out_fetch_full),
        .in_flush         (in_flush),
        .in_rob_full      (in_rob_full),
        .in_rs_full       (in_rs_full),
        .in_lsb_full      (in_lsb_full),
        .out_issue_valid  (out_issue_valid),
        .out_to_lsb       (out_to_lsb),
        .out_inst         (out_inst),
        .out_pc           (out_pc),
        .out_imm          (out_imm),
        .out_rd           (out_rd),
        .out_rs1          (out_rs1),
        .out_rs2          (out_rs2),
        .out_use_rs1      (out_use_rs1),
        .out_use_rs2      (out_use_rs2),
        .out_reg_write    (out_reg_write),
        .out_predict      (out_predict)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        to_lsb;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_rs1;
        logic        use_rs2;
        logic        reg_write;
        logic        predict;
    } dec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t mq[$];
    logic exp_valid;
    dec_t exp_f;
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic dec_t ref_decode(input ent_t e);
        dec_t        d;
        logic [31:0] i;
        logic [6:0]  op;
        int          v;
        bit          known;
        i  = e.inst;
        op = i[6:0];
        d  = '0;
        d.inst    = i;
        d.pc      = e.pc;
        d.predict = e.pred;
        d.rd      = i[11:7];
        d.rs1     = i[19:15];
        d.rs2     = i[24:20];
        known       = op inside {OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore,
                                 OpImm, OpReg};
        d.to_lsb    = (op == OpLoad) || (op == OpStore);
        d.use_rs1   = known && !(op inside {OpLui, OpAuipc, OpJal});
        d.use_rs2   = op inside {OpReg, OpStore, OpBranch};
        d.reg_write = known && !(op inside {OpStore, OpBranch}) && (i[11:7] != 5'd0);
        case (op)
            OpLui, OpAuipc: v = int'(i & 32'hFFFF_F000);
            OpJal: v = (i[31] ? -(1 << 20) : 0) + (int'(i[19:12]) << 12) +
                       (int'(i[20]) << 11) + (int'(i[30:21]) << 1);
            OpJalr, OpLoad: v = int'($signed(i)) >>> 20;
            OpImm: begin
                if (i[14:12] == 3'b001 || i[14:12] == 3'b101) v = int'(i[24:20]);
                else v = int'($signed(i)) >>> 20;
            end
            OpBranch: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 +
                          int'(i[11:8]) * 2;
            OpStore: v = (int'($signed(i)) >>> 25) * 32 + int'(i[11:7]);
            default: v = 0;
        endcase
        d.imm = 32'(v);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        dec_t got;
        got = {out_to_lsb, out_inst, out_pc, out_imm, out_rd, out_rs1, out_rs2,
               out_use_rs1, out_use_rs2, out_reg_write, out_predict};
        chk({tag, ".valid"}, 128'(out_issue_valid), 128'(exp_valid));
        chk({tag, ".full"}, 128'(out_fetch_full), 128'(mq.size() == DEPTH));
        chk({tag, ".fields"}, 128'(got), 128'(exp_f));
    endtask

    // Model reacts to the inputs present just before the active edge
    task automatic model_step();
        dec_t d;
        bit   can_enq;
        bit   do_deq;
        if (in_flush) begin
            mq.delete();
            exp_valid = 1'b0;
        end else if (!rdy_in) begin
            exp_valid = 1'b0;
        end else begin
            can_enq = in_fetch_valid && (mq.size() < DEPTH);
            do_deq  = 1'b0;
            if (mq.size() > 0) begin
                d      = ref_decode(mq[0]);
                do_deq = !in_rob_full && !(d.to_lsb ? in_lsb_full : in_rs_full);
            end
            exp_valid = do_deq;
            if (do_deq) begin
                exp_f = d;
                void'(mq.pop_front());
            end
            if (can_enq) mq.push_back('{in_fetch_inst, in_fetch_pc, in_fetch_predict});
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk_in);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        in_fetch_valid   = 1'b0;
        in_fetch_inst    = '0;
        in_fetch_pc      = '0;
        in_fetch_predict = 1'b0;
        in_flush         = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
        in_fetch_valid   = 1'b1;
        in_fetch_inst    = inst;
        in_fetch_pc      = pc;
        in_fetch_predict = pred;
    endtask

    // Called mid-cycle: reset takes effect without waiting for a clock edge
    task automatic async_reset(input string tag);
        rst_in = 1'b1;
        #1;
        mq.delete();
        exp_valid = 1'b0;
        exp_f     = '0;
        check_outputs(tag);
        rst_in = 1'b0;
    endtask

    function automatic logic [31:0] addi(input int rd, input int imm);
        logic [11:0] im;
        logic [4:0]  r;
        im = 12'(imm);
        r  = 5'(rd);
        return {im, 5'd0, 3'b000, r, OpImm};
    endfunction

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] rnd;
        ops = '{OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore, OpImm, OpReg, 7'b0001111};

        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        in_rob_full = 1'b0;
        in_rs_full  = 1'b0;
        in_lsb_full = 1'b0;
        idle();
        exp_valid = 1'b0;
        exp_f     = '0;
        #1;
        check_outputs("reset");
        #2;
        rst_in = 1'b0;

        // addi x1,x0,5: enqueued at one edge, issued at the next
        fetch(32'h0050_0093, 32'h0, 1'b0);
        tick("addi_enq");
        chk("addi_enq_no_issue", 128'(out_issue_valid), 128'(0));
        idle();
        tick("addi_issue");
        chk("addi_valid", 128'(out_issue_valid), 128'(1));
        chk("addi_imm", 128'(out_imm), 128'(5));
        chk("addi_rd", 128'(out_rd), 128'(1));
        chk("addi_regw", 128'(out_reg_write), 128'(1));
        chk("addi_lsb", 128'(out_to_lsb), 128'(0));
        chk("addi_rs2", 128'(out_use_rs2), 128'(0));
        tick("addi_after");

        // Fill with RS blocked; ninth offer refused; drain in order across wrap
        in_rs_full = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            fetch(addi(k + 1, k + 10), 32'h100 + 32'(4 * k), 1'b0);
            tick("fill");
        end
        chk("fill_full", 128'(out_fetch_full), 128'(1));
        fetch(addi(20, 99), 32'h200, 1'b0);
        tick("ninth_refused");
        chk("ninth_full", 128'(out_fetch_full), 128'(1));
        idle();
        in_rs_full = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tick("drain");
            chk("drain_valid", 128'(out_issue_valid), 128'(1));
            chk("drain_pc", 128'(out_pc), 128'(32'h100 + 32'(4 * k)));
        end
        tick("drain_done");
        chk("drain_done_valid", 128'(out_issue_valid), 128'(0));
        chk("drain_done_full", 128'(out_fetch_full), 128'(0));

        // sw x2,-4(x1) held back by LSB full only
        in_lsb_full = 1'b1;
        fetch(32'hFE20_AE23, 32'h300, 1'b0);
        tick("sw_enq");
        idle();
        for (int k = 0; k < 3; k++) begin
            tick("sw_blocked");
            chk("sw_blocked_valid", 128'(out_issue_valid), 128'(0));
        end
        in_lsb_full = 1'b0;
        tick("sw_issue");
        chk("sw_valid", 128'(out_issue_valid), 128'(1));
        chk("sw_lsb", 128'(out_to_lsb), 128'(1));
        chk("sw_imm", 128'(out_imm), 128'(32'hFFFF_FFFC));
        chk("sw_regw", 128'(out_reg_write), 128'(0));
        chk("sw_rs2", 128'(out_use_rs2), 128'(1));

        // srai x3,x3,4 then beq x1,x2,+8 predicted taken
        fetch(32'h4041_D193, 32'h400, 1'b0);
        tick("srai_enq");
        fetch(32'h0020_8463, 32'h404, 1'b1);
        tick("srai_issue");
        chk("srai_imm", 128'(out_imm), 128'(4));
        chk("srai_rd", 128'(out_rd), 128'(3));
        idle();
        tick("beq_issue");
        chk("beq_pred", 128'(out_predict), 128'(1));
        chk("beq_regw", 128'(out_reg_write), 128'(0));
        chk("beq_imm", 128'(out_imm), 128'(8));

        // Flush with a same-cycle fetch on a 4-entry queue
        in_rs_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fetch(addi(5, 100 + k), 32'h500 + 32'(4 * k), 1'b0);
            tick("pre_flush");
        end
        fetch(addi(6, 200), 32'h600, 1'b0);
        in_flush = 1'b1;
        tick("flush");
        chk("flush_valid", 128'(out_issue_valid), 128'(0));
        chk("flush_full", 128'(out_fetch_full), 128'(0));
        idle();
        in_rs_full = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick("post_flush");
            chk("post_flush_valid", 128'(out_issue_valid), 128'(0));
        end

        // rdy_in low freezes issue; flush still wins while rdy_in is low
        fetch(addi(7, 7), 32'h700, 1'b0);
        tick("rdy_enq");
        idle();
        rdy_in = 1'b0;
        tick("rdy_low");
        chk("rdy_low_valid", 128'(out_issue_valid), 128'(0));
        rdy_in = 1'b1;
        tick("rdy_high");
        chk("rdy_high_pc", 128'(out_pc), 128'(32'h700));
        in_rs_full = 1'b1;
        fetch(addi(8, 8), 32'h800, 1'b0);
        tick("rdy_flush_enq");
        idle();
        rdy_in   = 1'b0;
        in_flush = 1'b1;
        tick("rdy_low_flush");
        in_flush   = 1'b0;
        rdy_in     = 1'b1;
        in_rs_full = 1'b0;
        tick("rdy_low_flush_after");
        chk("rdy_low_flush_valid", 128'(out_issue_valid), 128'(0));

        // Asynchronous reset with 3 entries queued
        in_rs_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fetch(addi(9, 300 + k), 32'h900 + 32'(4 * k), 1'b0);
            tick("pre_reset");
        end
        idle();
        async_reset("mid_reset");
        chk("mid_reset_inst", 128'(out_inst), 128'(0));
        in_rs_full = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick("post_reset");
            chk("post_reset_valid", 128'(out_issue_valid), 128'(0));
        end
        fetch(addi(10, 42), 32'hA00, 1'b0);
        tick("post_reset_enq");
        idle();
        tick("post_reset_issue");
        chk("post_reset_pc", 128'(out_pc), 128'(32'hA00));

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rnd              = $urandom();
            in_fetch_valid   = ($urandom_range(0, 9) < 6);
            in_fetch_inst    = {rnd[31:7], ops[$urandom_range(0, 9)]};
            in_fetch_pc      = $urandom() & 32'hFFFF_FFFC;
            in_fetch_predict = 1'($urandom_range(0, 1));
            in_flush         = ($urandom_range(0, 49) == 0);
            in_rob_full      = ($urandom_range(0, 9) == 0);
            in_rs_full       = ($urandom_range(0, 4) == 0);
            in_lsb_full      = ($urandom_range(0, 4) == 0);
            rdy_in           = ($urandom_range(0, 9) != 0);
            tick("rand");
            if ($urandom_range(0, 499) == 0) async_reset("rand_reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, instruction-queue entries (power of two, >=2).
REQ-002 SHALL have parameter PTR_W, default 3, queue pointer width (log2 DEPTH).
REQ-003 SHALL have parameter XLEN, default 32, instruction, PC and immediate width.
REQ-004 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 rdy_in  input  1  global enable; low freezes all state except REQ-020.
REQ-007 in_fetch_valid  input  1  fetcher offers an instruction this cycle.
REQ-008 in_fetch_inst  input  XLEN  raw instruction.
REQ-009 in_fetch_pc  input  XLEN  instruction PC.
REQ-010 in_fetch_predict  input  1  branch-predictor taken bit.
REQ-011 out_fetch_full  output  1  queue holds DEPTH entries; fetcher must stall.
REQ-012 in_flush  input  1  ROB rollback (mispredict); discard all queued work.
REQ-013 in_rob_full, in_rs_full, in_lsb_full  input  1 each  downstream capacity flags.
REQ-014 out_issue_valid  output  1  one-cycle pulse: registered issue fields valid.
REQ-015 out_to_lsb  output  1  1 = LSB, 0 = RS.
REQ-016 out_inst, out_pc, out_imm  output  XLEN each  raw instruction, PC, decoded immediate.
REQ-017 out_rd, out_rs1, out_rs2  output  5 each  inst[11:7], [19:15], [24:20].
REQ-018 out_use_rs1, out_use_rs2, out_reg_write, out_predict  output  1 each  operand use, rd write, carried prediction.

Function
REQ-019 Enqueue: in_fetch_valid && rdy_in && !in_flush && count<DEPTH writes {inst,pc,predict} at tail; tail wraps DEPTH-1 -> 0.
REQ-020 With rdy_in low: no enqueue, dequeue or pointer change; out_issue_valid cleared at the edge; other outputs hold.
REQ-021 Dequeue (issue) when count>0 && rdy_in && !in_flush && !in_rob_full && !(head targets LSB ? in_lsb_full : in_rs_full); head wraps DEPTH-1 -> 0.
REQ-022 On issue: decoded head fields registered onto outputs, out_issue_valid=1 next cycle; no issue -> out_issue_valid=0, other outputs hold.
REQ-023 Latency: instruction enqueued at edge N into empty, unblocked queue SHALL show out_issue_valid=1 after edge N+1.
REQ-024 Simultaneous enqueue and dequeue: count unchanged; allowed when count<DEPTH; at count==DEPTH enqueue refused even if dequeue occurs.
REQ-025 out_fetch_full = (count==DEPTH), combinational from count.
REQ-026 Flush: head, tail, count to 0; out_issue_valid 0 next cycle; same-cycle fetch and issue discarded; flush overrides rdy_in low.
REQ-027 Target: LSB for opcode 0000011 (LOAD) and 0100011 (STORE); RS for all else.
REQ-028 out_use_rs1=0 for LUI 0110111, AUIPC 0010111, JAL 1101111; else 1.
REQ-029 out_use_rs2=1 only for OP 0110011, STORE, BRANCH 1100011.
REQ-030 out_reg_write=0 for STORE/BRANCH or rd==0; else 1.
REQ-031 Immediates: LUI/AUIPC {i[31:12],12'b0}; JAL J-type, bit0=0; JALR/LOAD/OP-IMM I-type sign-extended; BRANCH B-type, bit0=0; STORE S-type; OP-IMM funct3 001/101 -> zero-extended i[24:20]; OP and unknown opcodes -> 0.
REQ-032 Unknown opcode: dequeued as normal, sent to RS, out_reg_write=0, out_use_rs1=out_use_rs2=0.
REQ-033 count SHALL never exceed DEPTH nor underflow.

Reset
REQ-034 rst_in high asynchronously clears head, tail, count, out_issue_valid, out_fetch_full and every registered output to 0.
REQ-035 Reset mid-operation discards queued entries; first post-reset issue is the first post-reset enqueue.

Verification
REQ-036 Empty queue, fetch 0x00500093 (addi x1,x0,5) pc 0x0 -> next-next edge out_issue_valid=1, out_imm=5, out_rd=1, out_reg_write=1, out_to_lsb=0, out_use_rs2=0.
REQ-037 in_rs_full=1, fetch 8 ALU ops -> out_fetch_full=1, 9th refused; release -> 8 consecutive issue pulses, original order, pointer wrap.
REQ-038 sw x2,-4(x1) (0xFE20AE23) with in_lsb_full=1, in_rs_full=0 -> no issue; clear -> out_to_lsb=1, out_imm=0xFFFFFFFC, out_reg_write=0, out_use_rs2=1.
REQ-039 4 queued entries, in_flush plus in_fetch_valid same cycle -> count=0, out_issue_valid=0, flushed and incoming instructions never issue.
REQ-040 srai x3,x3,4 (0x4041D193) -> out_imm=4; beq predict=1 -> out_predict=1, out_reg_write=0, B-imm correct.
REQ-041 rst_in asserted between edges with 3 entries -> outputs 0 immediately, no issue until new fetch.
